// File: rtl/prog_bool_lut_pkg.sv
// Shared types and helpers for the programmable boolean LUT.
package prog_bool_lut_pkg;

    typedef enum logic [1:0] {
        ST_UNPROG = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    function automatic int unsigned tt_width(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/bool_lut_ch.sv
// One channel: active truth table plus registered N_IN-to-1 lookup.
module bool_lut_ch
    import prog_bool_lut_pkg::*;
#(
    parameter  int unsigned N_IN = 4,
    localparam int unsigned TT_W = tt_width(N_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [TT_W-1:0]   wdata_i,
    input  logic              en_i,
    input  logic [N_IN-1:0]   sel_i,
    output logic              y_o
);

    logic [TT_W-1:0] table_q;
    logic            y_q;

    // Lookup reads the pre-write table, so a vector on the commit edge sees the old function.
    always_ff @(posedge clk) begin
        if (rst) begin
            table_q <= '0;
            y_q     <= 1'b0;
        end else begin
            if (we_i) begin
                table_q <= wdata_i;
            end
            if (en_i) begin
                y_q <= table_q[sel_i];
            end
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/prog_bool_lut.sv
// Programmable registered boolean evaluator: bit-serial table loader, N_CH lookup channels.
module prog_bool_lut
    import prog_bool_lut_pkg::*;
#(
    parameter  int unsigned N_IN = 4,
    parameter  int unsigned N_CH = 2,
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic              cfg_valid,
    input  logic              cfg_bit,
    output logic              cfg_ready,
    output logic              cfg_done,
    output logic              cfg_err,
    input  logic              in_valid,
    input  logic [N_IN-1:0]   in_data,
    output logic              out_valid,
    output logic [N_CH-1:0]   y,
    output logic              armed
);

    localparam int unsigned TT_W = tt_width(N_IN);

    state_e            state_q;
    logic [TT_W-1:0]   shadow_q;
    logic [TT_W-1:0]   shadow_d;
    logic [N_IN-1:0]   cnt_q;
    logic [CH_W-1:0]   ch_q;
    logic              armed_q;
    logic              ready_q;
    logic              done_q;
    logic              err_q;
    logic              out_valid_q;

    logic              start_ok_c;
    logic              accept_c;
    logic              last_c;

    // A start pulse always wins over a bit presented in the same cycle.
    assign start_ok_c = cfg_start && (32'(cfg_ch) < N_CH);
    assign accept_c   = (state_q == ST_LOAD) && cfg_valid && !cfg_start;
    assign last_c     = accept_c && (cnt_q == N_IN'(TT_W - 1));
    assign shadow_d   = {cfg_bit, shadow_q[TT_W-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_UNPROG;
            shadow_q    <= '0;
            cnt_q       <= '0;
            ch_q        <= '0;
            armed_q     <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= in_valid;
            if (cfg_start) begin
                shadow_q <= '0;
                cnt_q    <= '0;
                if (start_ok_c) begin
                    state_q <= ST_LOAD;
                    ch_q    <= cfg_ch;
                    ready_q <= 1'b1;
                end else begin
                    state_q <= armed_q ? ST_RUN : ST_UNPROG;
                    ready_q <= 1'b0;
                    err_q   <= 1'b1;
                end
            end else if (accept_c) begin
                shadow_q <= shadow_d;
                if (last_c) begin
                    state_q <= ST_RUN;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                    done_q  <= 1'b1;
                    armed_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + N_IN'(1);
                end
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        bool_lut_ch #(.N_IN(N_IN)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .we_i    (last_c && (ch_q == CH_W'(k))),
            .wdata_i (shadow_d),
            .en_i    (in_valid),
            .sel_i   (in_data),
            .y_o     (y[k])
        );
    end

    assign cfg_ready = ready_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign out_valid = out_valid_q;
    assign armed     = armed_q;

endmodule

// File: tb/tb_prog_bool_lut.sv
// Scoreboard bench for prog_bool_lut, built with three channels so an out-of-range channel is encodable.
module tb_prog_bool_lut;

    localparam int unsigned N_IN = 4;
    localparam int unsigned N_CH = 3;
    localparam int unsigned CH_W = 2;
    localparam int unsigned TT_W = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_start;
    logic [CH_W-1:0] cfg_ch;
    logic            cfg_valid;
    logic            cfg_bit;
    logic            cfg_ready;
    logic            cfg_done;
    logic            cfg_err;
    logic            in_valid;
    logic [N_IN-1:0] in_data;
    logic            out_valid;
    logic [N_CH-1:0] y;
    logic            armed;

    always #5 clk = ~clk;

    prog_bool_lut #(.N_IN(N_IN), .N_CH(N_CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_ch    (cfg_ch),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .y         (y),
        .armed     (armed)
    );

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    bit rand_in = 1'b0;

    // Reference model state
    logic [TT_W-1:0] m_tt [N_CH];
    logic [TT_W-1:0] m_sh;
    bit              m_load, m_armed, m_done, m_err;
    int              m_ch, m_cnt;
    logic [N_CH-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N_CH-1:0] eval(input logic [N_IN-1:0] d);
        logic [N_CH-1:0] r;
        for (int k = 0; k < N_CH; k++) r[k] = m_tt[k][d];
        return r;
    endfunction

    // One clock: push expectation from pre-edge tables, advance the model, then compare control outputs.
    task automatic tick();
        if (!rst && in_valid) exp_q.push_back(eval(in_data));
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            for (int k = 0; k < N_CH; k++) m_tt[k] = '0;
            m_load  = 1'b0;
            m_armed = 1'b0;
            m_cnt   = 0;
            m_sh    = '0;
        end else if (cfg_start) begin
            m_cnt = 0;
            m_sh  = '0;
            if (int'(cfg_ch) < N_CH) begin
                m_load = 1'b1;
                m_ch   = int'(cfg_ch);
            end else begin
                m_load = 1'b0;
                m_err  = 1'b1;
            end
        end else if (m_load && cfg_valid) begin
            m_sh[m_cnt] = cfg_bit;
            if (m_cnt == TT_W - 1) begin
                m_tt[m_ch] = m_sh;
                m_load  = 1'b0;
                m_armed = 1'b1;
                m_done  = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        check("cfg_ready", 32'(cfg_ready), 32'(m_load));
        check("cfg_done", 32'(cfg_done), 32'(m_done));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
        check("armed", 32'(armed), 32'(m_armed));
        if (cfg_done === 1'b1) done_cnt++;
    endtask

    task automatic load(input int ch, input logic [TT_W-1:0] tt, input int nbits);
        cfg_start = 1'b1;
        cfg_ch    = CH_W'(ch);
        if (rand_in) in_data = N_IN'($urandom_range(0, 15));
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = tt[i];
            if (rand_in) in_data = N_IN'($urandom_range(0, 15));
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL y_extra: got out_valid with y=%0h, expected no output", y);
            end else begin
                check("y", 32'(y), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int d0;
        for (int k = 0; k < N_CH; k++) m_tt[k] = '0;
        m_sh = '0; m_load = 1'b0; m_armed = 1'b0; m_ch = 0; m_cnt = 0;
        rst = 1'b1; cfg_start = 1'b0; cfg_ch = '0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        in_valid = 1'b1; in_data = 4'hF;

        // Reset
        tick();
        tick();
        check("rst_y", 32'(y), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_y", 32'(y), 32'd0);

        // Program AND on ch0 and "not all equal" on ch1
        rand_in = 1'b1;
        load(0, 16'h8000, 16);
        check("armed_first", 32'(armed), 32'd1);
        load(1, 16'h7FFE, 16);
        check("done_count", 32'(done_cnt), 32'd2);
        rand_in = 1'b0;
        for (int d = 0; d < 16; d++) begin
            in_data = N_IN'(d);
            tick();
            check("and4", 32'(y[0]), 32'(d == 15));
            check("neq4", 32'(y[1]), 32'(d != 0 && d != 15));
            check("ch2_zero", 32'(y[2]), 32'd0);
        end

        // Commit boundary
        load(0, 16'h0000, 16);
        in_data = 4'h5;
        load(0, 16'hFFFF, 16);
        check("commit_old", 32'(y[0]), 32'd0);
        tick();
        check("commit_new", 32'(y[0]), 32'd1);

        // Abort and restart on another channel
        d0 = done_cnt;
        rand_in = 1'b1;
        load(0, 16'h00FF, 7);
        load(1, 16'hAAAA, 16);
        check("abort_done", 32'(done_cnt - d0), 32'd1);
        rand_in = 1'b0;
        for (int d = 0; d < 4; d++) begin
            in_data = N_IN'(d);
            tick();
            check("abort_ch0", 32'(y[0]), 32'd1);
            check("abort_ch1", 32'(y[1]), 32'(d % 2));
        end

        // Out-of-range channel while armed
        cfg_start = 1'b1;
        cfg_ch    = 2'd3;
        tick();
        cfg_start = 1'b0;
        check("err_pulse", 32'(cfg_err), 32'd1);
        check("err_ready", 32'(cfg_ready), 32'd0);
        check("err_armed", 32'(armed), 32'd1);
        tick();
        check("err_clear", 32'(cfg_err), 32'd0);

        // Out-of-range channel aborts a load in progress; later bits ignored
        d0 = done_cnt;
        load(2, 16'hFFFF, 5);
        cfg_start = 1'b1;
        cfg_ch    = 2'd3;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
        check("err_no_commit", 32'(done_cnt - d0), 32'd0);
        in_data = 4'h0;
        tick();
        check("ch2_unchanged", 32'(y[2]), 32'd0);

        // Reset mid-load
        load(2, 16'hFFFF, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_armed", 32'(armed), 32'd0);
        check("midrst_ready", 32'(cfg_ready), 32'd0);
        in_data = 4'hF;
        tick();
        check("midrst_y", 32'(y), 32'd0);
        load(1, 16'h7FFE, 16);
        check("reload_armed", 32'(armed), 32'd1);
        in_data = 4'h1;
        tick();
        check("reload_y", 32'(y), 32'b010);

        in_valid = 1'b0;
        tick();
        tick();
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_bool_lut.md
# prog_bool_lut

- Programmable, registered boolean-function evaluator.
- Each of `N_CH` channels holds a `2**N_IN`-entry truth table, loaded bit-serially at run time.
- Every accepted input vector produces one registered output bit per channel.
- Successor to the team's fixed 4-input combinational expression blocks: one instance replaces any hard-wired `y = f(a,b,c,d)`, and a function can be reprogrammed while evaluation continues.

## Interface
- `N_IN`, 4, number of boolean inputs (1..8); table width `TT_W = 2**N_IN`.
- `N_CH`, 2, number of independent output channels (1..16); `CH_W = max(1, $clog2(N_CH))`.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_start`  in  1  pulse: begin loading the table of channel `cfg_ch`.
- `cfg_ch`  in  CH_W  target channel, sampled only with `cfg_start`.
- `cfg_valid`  in  1  `cfg_bit` is valid this cycle.
- `cfg_bit`  in  1  next truth-table bit, index 0 first.
- `cfg_ready`  out  1  high while in LOAD; a bit is accepted when `cfg_valid & cfg_ready`.
- `cfg_done`  out  1  one-cycle pulse when a table is committed.
- `cfg_err`  out  1  one-cycle pulse when `cfg_start` names `cfg_ch >= N_CH`.
- `in_valid`  in  1  `in_data` valid; always accepted, no backpressure.
- `in_data`  in  N_IN  input vector; `in_data[0]` is the first variable.
- `out_valid`  out  1  `y` valid.
- `y`  out  N_CH  `y[k] = table_k[in_data]` for the accepted vector.
- `armed`  out  1  set by the first commit; cleared only by reset.

## Operation
- FSM states: UNPROG, LOAD, RUN (encoding lives in the package).
  - UNPROG → LOAD on a valid `cfg_start`.
  - LOAD → RUN when the last bit is committed.
  - RUN → LOAD on a valid `cfg_start`.
  - LOAD → LOAD on `cfg_start`: abort and restart. The shadow register and bit counter clear, the new `cfg_ch` is latched, and no commit occurs.
  - UNPROG returns to UNPROG if a load is aborted by an invalid `cfg_start`.
- Loading:
  - Accepted bits shift into a `TT_W`-bit shadow register; bit counter runs 0..TT_W-1.
  - On acceptance of bit `TT_W-1`, the full shadow is written to the active table of the latched channel, `cfg_done` pulses, and the FSM goes to RUN.
- Evaluation is independent of FSM state and uses the active tables only. A channel being reloaded keeps its old function until commit.
- Invalid `cfg_start` (`cfg_ch >= N_CH`):
  - Pulses `cfg_err`.
  - Any load in progress is aborted.
  - FSM returns to RUN if `armed`, otherwise UNPROG.
- `cfg_start` and `cfg_valid` in the same cycle: the bit is ignored, because the counter restarts.
- `cfg_valid` outside LOAD is ignored.
- Reset values: all tables 0, shadow 0, counter 0, FSM UNPROG, `y` 0. All of `out_valid`, `cfg_ready`, `cfg_done`, `cfg_err` and `armed` are 0.

## Timing
- Evaluation latency is 1 cycle: `in_valid`/`in_data` sampled at edge n give `out_valid` and `y` at edge n+1. Full throughput, one vector per cycle.
- `y` holds its last value when `out_valid` is 0.
- Commit edge: a vector sampled on the same edge as the last config bit uses the old table. The following edge uses the new table.
- `cfg_done` is asserted in the cycle after the last bit is accepted. `cfg_ready` is 0 in that same cycle.
- Minimum load time is `TT_W` cycles after `cfg_start`. `cfg_ready` rises the cycle after `cfg_start`.
- Reset asserted mid-load discards the partial table, the commit and `armed`. Outputs read reset values on the cycle after the `rst` edge.

## Structure
- Package `prog_bool_lut_pkg`: FSM state typedef (UNPROG/LOAD/RUN) and a `tt_width(n)` function returning `2**n`.
- Sub-module `bool_lut_ch`, instantiated `N_CH` times. It holds one active table register with a write-enable/data port and a registered `N_IN`→1 mux output.
- Top level owns the FSM, shadow register, counter, channel decode and `out_valid` pipe.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `in_valid=1`, `in_data=4'hF` → `y=0`, `out_valid=0`, `armed=0`, `cfg_ready=0`; one cycle after release, `out_valid=1`, `y=2'b00`.
- **Program and evaluate:**
  - Program ch0 with `16'h8000` (4-input AND) and ch1 with `16'h7FFE` (neither all-0 nor all-1).
  - Then sweep `in_data` 0..15 → `y[0]=1` only for `4'hF`, `y[1]=0` only for `4'h0` and `4'hF`.
  - `cfg_done` pulses once per channel; `armed=1` after the first commit.
- **Commit boundary:** ch0 = `16'h0000`. Reload with `16'hFFFF` while streaming `in_data=4'h5` every cycle → `y[0]=0` for the vector on the last-bit edge, 1 for the next vector.
- **Abort:** `cfg_start` ch0, feed 7 bits, `cfg_start` ch1, feed 16 bits of `16'hAAAA` → ch0 table unchanged, ch1 = `16'hAAAA`, exactly one `cfg_done`.
- **Error:** with `N_CH=2`, `CH_W=1` cannot encode an out-of-range channel. Run with `N_CH=3`, `cfg_ch=2'd3` → `cfg_err` pulse, `cfg_ready=0`, state unchanged.
- **Mid-load reset:** reset after 10 of 16 bits → all tables 0, `armed=0`; a subsequent full load succeeds normally.
